// File: rtl/maze_game_ctrl.sv
// maze_game_ctrl: round sequencer for the maze game.
// Detects start presses, runs a 3-2-1 countdown, enables the Timer during play,
// ends the round on goal or time limit, and latches the final time.
// Optional best-time record is compiled in when MAZE_CTRL_BEST_EN is defined;
// otherwise o_Best/o_BestValid/o_NewBest are tied to 0.
module maze_game_ctrl #(
  parameter int          TICK_CYCLES = 100000000,
  parameter logic [11:0] TIME_LIMIT  = 12'h300
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  input  logic        i_Goal,
  input  logic [3:0]  i_Sec0,
  input  logic [3:0]  i_Sec1,
  input  logic [3:0]  i_Sec2,
  output logic        o_TimerEnable,
  output logic [1:0]  o_State,
  output logic [1:0]  o_Countdown,
  output logic        o_TimedOut,
  output logic [11:0] o_Final,
  output logic [11:0] o_Best,
  output logic        o_BestValid,
  output logic        o_NewBest
);

  typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  localparam int            TW        = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic          start_q;   // previous-cycle button sample; resets high so a held button is not a start
  logic          start_ev;
  logic [11:0]   digits;

  assign start_ev = i_Start & ~start_q;
  assign digits   = {i_Sec2, i_Sec1, i_Sec0};
  assign o_State  = state;

  // Round FSM: state, countdown, timer enable and end-of-round latch
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      start_q       <= 1'b1;
      o_Countdown   <= 2'd0;
      o_TimerEnable <= 1'b0;
      o_TimedOut    <= 1'b0;
      o_Final       <= 12'h000;
    end else begin
      start_q <= i_Start;
      case (state)
        IDLE: begin
          if (start_ev) begin
            state       <= READY;
            o_Countdown <= 2'd3;
            tick_cnt    <= '0;
            o_Final     <= 12'h000;
            o_TimedOut  <= 1'b0;
          end
        end
        READY: begin
          if (start_ev) begin
            state       <= IDLE;
            o_Countdown <= 2'd0;
            tick_cnt    <= '0;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (o_Countdown == 2'd1) begin
              state         <= RUN;
              o_Countdown   <= 2'd0;
              o_TimerEnable <= 1'b1;
            end else begin
              o_Countdown <= o_Countdown - 2'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        RUN: begin
          // abort beats goal, goal beats time limit
          if (start_ev) begin
            state         <= IDLE;
            o_TimerEnable <= 1'b0;
          end else if (i_Goal) begin
            state         <= DONE;
            o_Final       <= digits;
            o_TimedOut    <= 1'b0;
            o_TimerEnable <= 1'b0;
          end else if (digits == TIME_LIMIT) begin
            state         <= DONE;
            o_Final       <= TIME_LIMIT;
            o_TimedOut    <= 1'b1;
            o_TimerEnable <= 1'b0;
          end
        end
        DONE: begin
          if (start_ev) begin
            state       <= READY;
            o_Countdown <= 2'd3;
            tick_cnt    <= '0;
            o_Final     <= 12'h000;
            o_TimedOut  <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          o_TimerEnable <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAZE_CTRL_BEST_EN
  // Best-clear record: updated on the same edge that latches o_Final for a goal finish
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Best      <= 12'h000;
      o_BestValid <= 1'b0;
      o_NewBest   <= 1'b0;
    end else begin
      o_NewBest <= 1'b0;
      if (state == RUN && !start_ev && i_Goal && (!o_BestValid || digits < o_Best)) begin
        o_Best      <= digits;
        o_BestValid <= 1'b1;
        o_NewBest   <= 1'b1;
      end
    end
  end
`else
  assign o_Best      = 12'h000;
  assign o_BestValid = 1'b0;
  assign o_NewBest   = 1'b0;
`endif

endmodule

// File: tb/tb_maze_game_ctrl.sv
// tb_maze_game_ctrl: directed test of the maze round sequencer
// (TICK_CYCLES=4, TIME_LIMIT=12'h005). Best-record expectations follow MAZE_CTRL_BEST_EN.
module tb_maze_game_ctrl;

`ifdef MAZE_CTRL_BEST_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  logic        i_Clk = 1'b0;
  logic        i_Rst, i_Start, i_Goal;
  logic [3:0]  i_Sec0, i_Sec1, i_Sec2;
  logic        o_TimerEnable, o_TimedOut, o_BestValid, o_NewBest;
  logic [1:0]  o_State, o_Countdown;
  logic [11:0] o_Final, o_Best;

  int n_chk  = 0;
  int n_fail = 0;

  maze_game_ctrl #(.TICK_CYCLES(4), .TIME_LIMIT(12'h005)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Goal(i_Goal),
    .i_Sec0(i_Sec0), .i_Sec1(i_Sec1), .i_Sec2(i_Sec2),
    .o_TimerEnable(o_TimerEnable), .o_State(o_State), .o_Countdown(o_Countdown),
    .o_TimedOut(o_TimedOut), .o_Final(o_Final), .o_Best(o_Best),
    .o_BestValid(o_BestValid), .o_NewBest(o_NewBest)
  );

  always #5 i_Clk = ~i_Clk;

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task step;
    @(posedge i_Clk);
    #1;
  endtask

  task press;
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
  endtask

  task set_dig(input logic [11:0] d);
    {i_Sec2, i_Sec1, i_Sec0} = d;
  endtask

  // from IDLE/DONE: press start then wait out the 12-cycle countdown
  task to_run;
    press();
    repeat (12) step();
    chk("to_run_state", 32'(o_State), 32'd2);
  endtask

  // finish a round in RUN with the given digits/goal, then check the outcome
  task finish(input string tag, input logic [11:0] d, input logic g,
              input logic [11:0] exp_final, input logic exp_to,
              input logic exp_nb, input logic [11:0] exp_best);
    set_dig(d);
    i_Goal = g;
    step();
    chk({tag, "_state"},  32'(o_State), 32'd3);
    chk({tag, "_final"},  32'(o_Final), 32'(exp_final));
    chk({tag, "_tout"},   32'(o_TimedOut), 32'(exp_to));
    chk({tag, "_newbest"},32'(o_NewBest), 32'(exp_nb & BE));
    chk({tag, "_best"},   32'(o_Best), BE ? 32'(exp_best) : 32'd0);
    chk({tag, "_en"},     32'(o_TimerEnable), 32'd0);
    i_Goal = 1'b0;
    set_dig(12'h000);
    step();
    chk({tag, "_nb_pulse"}, 32'(o_NewBest), 32'd0);
    chk({tag, "_hold"},     32'(o_Final), 32'(exp_final));
  endtask

  initial begin
    i_Rst = 1'b1; i_Start = 1'b1; i_Goal = 1'b0;
    set_dig(12'h000);
    repeat (2) step();
    chk("rst_state", 32'(o_State), 32'd0);
    chk("rst_en",    32'(o_TimerEnable), 32'd0);
    chk("rst_cd",    32'(o_Countdown), 32'd0);
    chk("rst_final", 32'(o_Final), 32'd0);
    chk("rst_best",  32'(o_Best), 32'd0);
    chk("rst_bv",    32'(o_BestValid), 32'd0);
    // button held through reset release must not start a round
    i_Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_state", 32'(o_State), 32'd0);
      chk("held_en",    32'(o_TimerEnable), 32'd0);
    end
    i_Start = 1'b0;
    step();

    // countdown timing: 4 cycles each of 3,2,1 then RUN
    press();
    for (int i = 0; i < 12; i++) begin
      chk("ready_state", 32'(o_State), 32'd1);
      chk("ready_cd",    32'(o_Countdown), 32'(3 - i / 4));
      chk("ready_en",    32'(o_TimerEnable), 32'd0);
      step();
    end
    chk("run_state", 32'(o_State), 32'd2);
    chk("run_en",    32'(o_TimerEnable), 32'd1);
    chk("run_cd",    32'(o_Countdown), 32'd0);
    // goal ignored during READY would show here; first clear at 002
    finish("clr002", 12'h002, 1'b1, 12'h002, 1'b0, 1'b1, 12'h002);
    chk("bv_after_clear", 32'(o_BestValid), 32'(BE));

    // new round from DONE clears the latched fields
    press();
    chk("newround_state", 32'(o_State), 32'd1);
    chk("newround_final", 32'(o_Final), 32'd0);
    chk("newround_cd",    32'(o_Countdown), 32'd3);
    repeat (12) step();
    chk("r2_state", 32'(o_State), 32'd2);
    finish("tout", 12'h005, 1'b0, 12'h005, 1'b1, 1'b0, 12'h002);

    to_run();
    finish("goal_lim", 12'h005, 1'b1, 12'h005, 1'b0, 1'b0, 12'h002);

    to_run();
    finish("clr003", 12'h003, 1'b1, 12'h003, 1'b0, 1'b0, 12'h002);

    to_run();
    finish("clr001", 12'h001, 1'b1, 12'h001, 1'b0, 1'b1, 12'h001);

    to_run();
    finish("eq001", 12'h001, 1'b1, 12'h001, 1'b0, 1'b0, 12'h001);

    // abort in RUN: back to IDLE, nothing latched
    to_run();
    set_dig(12'h002);
    press();
    chk("abort_state", 32'(o_State), 32'd0);
    chk("abort_final", 32'(o_Final), 32'd0);
    chk("abort_en",    32'(o_TimerEnable), 32'd0);
    chk("abort_best",  32'(o_Best), BE ? 32'h001 : 32'd0);
    set_dig(12'h000);
    step();

    // asynchronous reset in READY
    press();
    step(); step();
    chk("pre_rst_state", 32'(o_State), 32'd1);
    #2 i_Rst = 1'b1;
    #1;
    chk("async_state", 32'(o_State), 32'd0);
    chk("async_cd",    32'(o_Countdown), 32'd0);
    chk("async_best",  32'(o_Best), 32'd0);
    chk("async_bv",    32'(o_BestValid), 32'd0);
    #2 i_Rst = 1'b0;
    step();
    chk("post_rst_state", 32'(o_State), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
